// File: rtl/score_overlay_pkg.sv
// score_overlay_pkg: register map, converter states and the 10x8 digit font
package score_overlay_pkg;
    localparam logic [2:0] ADDR_SCORE = 3'd0;
    localparam logic [2:0] ADDR_POS_X = 3'd1;
    localparam logic [2:0] ADDR_POS_Y = 3'd2;
    localparam logic [2:0] ADDR_CTRL  = 3'd3;

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} conv_state_t;

    // row 0 is the top of the glyph, MSB is the leftmost pixel
    localparam logic [7:0] FONT [10][8] = '{
        '{8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00},
        '{8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00},
        '{8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E, 8'h00},
        '{8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00},
        '{8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'h7E, 8'h0C, 8'h0C, 8'h00},
        '{8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00},
        '{8'h3C, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00},
        '{8'h7E, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30, 8'h00},
        '{8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h00},
        '{8'h3C, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h0C, 8'h38, 8'h00}
    };
endpackage

// File: rtl/score_overlay_font.sv
// digit_font_rom: registered glyph row lookup; codes above 9 read as blank
module digit_font_rom
    import score_overlay_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit,
    input  logic [2:0] row,
    output logic [7:0] glyph
);
    always_ff @(posedge clk) begin
        if (reset) glyph <= 8'h00;
        else glyph <= (digit > 4'd9) ? 8'h00 : FONT[digit][row];
    end
endmodule

// File: rtl/score_overlay.sv
// score_overlay: register-mapped score counter with double-dabble conversion
// and a two-stage pipelined digit renderer for a 640x480 raster.
module score_overlay
    import score_overlay_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCORE_W    = 14,
    parameter int SCALE_LOG2 = 0,
    parameter int RESET_X    = 225,
    parameter int RESET_Y    = 441
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic [2:0]  address,
    input  logic [31:0] writedata,
    input  logic        score_inc,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    output logic        pixel_on,
    output logic        busy,
    output logic        overflow
);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CW = $clog2(SCORE_W + 1);
    localparam logic [31:0] MAX = 32'(10 ** NUM_DIGITS - 1);
    localparam logic [SCORE_W-1:0] MAX_S = MAX[SCORE_W-1:0];
    localparam int CELL = 8 << SCALE_LOG2;
    localparam int PITCH = 10 << SCALE_LOG2;

    logic [SCORE_W-1:0] score, score_nx;
    logic [9:0] pos_x;
    logic [8:0] pos_y;
    logic enable, blank, dirty, wr, wr_score, start;
    conv_state_t state;
    logic [CW-1:0] cnt;
    logic [BCD_W+SCORE_W-1:0] dd, dd_adj;
    logic [BCD_W-1:0] digits;

    assign wr = chipselect && write;
    assign wr_score = wr && address == ADDR_SCORE;
    // a write beats a simultaneous increment; increments saturate at MAX
    assign score_nx = wr_score ? (writedata > MAX ? MAX_S : writedata[SCORE_W-1:0])
                    : (score_inc && score != MAX_S) ? score + 1'b1 : score;
    assign start = state == IDLE && dirty && vcount >= 10'd480 && vcount <= 10'd523;
    assign busy = state != IDLE;

    always_ff @(posedge clk) begin
        if (reset) begin
            score    <= '0;
            pos_x    <= 10'(RESET_X);
            pos_y    <= 9'(RESET_Y);
            enable   <= 1'b1;
            blank    <= 1'b0;
            dirty    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            score <= score_nx;
            dirty <= score_nx != score || (dirty && !start);
            if (wr && address == ADDR_POS_X) pos_x <= writedata[9:0];
            if (wr && address == ADDR_POS_Y) pos_y <= writedata[8:0];
            if (wr && address == ADDR_CTRL) begin
                enable <= writedata[0];
                blank  <= writedata[1];
            end
            if (score_inc && !wr_score && score == MAX_S) overflow <= 1'b1;
            else if (wr && address == ADDR_CTRL && writedata[2]) overflow <= 1'b0;
        end
    end

    always_comb begin
        dd_adj = dd;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (dd[SCORE_W+4*i +: 4] >= 4'd5) dd_adj[SCORE_W+4*i +: 4] = dd[SCORE_W+4*i +: 4] + 4'd3;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            dd     <= '0;
            digits <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= SHIFT;
                    cnt   <= '0;
                    dd    <= {{BCD_W{1'b0}}, score};
                end
                SHIFT: begin
                    dd  <= dd_adj << 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(SCORE_W - 1)) state <= LATCH;
                end
                LATCH: begin
                    digits <= dd[BCD_W+SCORE_W-1 -: BCD_W];
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [11:0] px, py, cx, dx, dy;
    logic hit, lz_blank, seen;
    logic [3:0] code, d;
    logic [2:0] col, row;
    logic s1_hit, s1_blank, s2_hit, s2_blank;
    logic [3:0] s1_code;
    logic [2:0] s1_row, s1_col, s2_col;
    logic [7:0] glyph;

    always_comb begin
        px = {2'b0, hcount[10:1]};
        py = {2'b0, vcount};
        dy = py - {3'b0, pos_y};
        hit = 1'b0;
        code = '0;
        col = '0;
        lz_blank = 1'b0;
        seen = 1'b0;
        cx = '0;
        dx = '0;
        d = '0;
        // digit 0 is most significant; seen tracks a nonzero digit to its left
        for (int i = 0; i < NUM_DIGITS; i++) begin
            cx = {2'b0, pos_x} + 12'(i * PITCH);
            dx = px - cx;
            d = digits[4*(NUM_DIGITS-1-i) +: 4];
            if (px >= cx && dx < 12'(CELL)) begin
                hit = 1'b1;
                code = d;
                col = 3'(dx >> SCALE_LOG2);
                lz_blank = blank && !seen && d == 4'd0 && i != NUM_DIGITS - 1;
            end
            seen = seen || d != 4'd0;
        end
        row = 3'(dy >> SCALE_LOG2);
        hit = hit && enable && hcount < 11'd1280 && vcount < 10'd480
              && py >= {3'b0, pos_y} && dy < 12'(CELL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_hit   <= 1'b0;
            s1_blank <= 1'b0;
            s1_code  <= '0;
            s1_row   <= '0;
            s1_col   <= '0;
            s2_hit   <= 1'b0;
            s2_blank <= 1'b0;
            s2_col   <= '0;
        end else begin
            s1_hit   <= hit;
            s1_blank <= lz_blank;
            s1_code  <= code;
            s1_row   <= row;
            s1_col   <= col;
            s2_hit   <= s1_hit;
            s2_blank <= s1_blank;
            s2_col   <= s1_col;
        end
    end

    digit_font_rom u_rom (
        .clk   (clk),
        .reset (reset),
        .digit (s1_code),
        .row   (s1_row),
        .glyph (glyph)
    );

    assign pixel_on = s2_hit && !s2_blank && glyph[3'd7 - s2_col];
endmodule

// File: tb/tb_score_overlay.sv
// tb_score_overlay: directed + randomized checks of score_overlay against a
// decimal/geometric reference model with its own copy of the glyph table.
module tb_score_overlay;
    logic clk = 1'b0, reset = 1'b1, chipselect = 1'b0, write = 1'b0, score_inc = 1'b0;
    logic [2:0] address = '0;
    logic [31:0] writedata = '0;
    logic [10:0] hcount = '0;
    logic [9:0] vcount = 10'd100;
    logic pixel_on, busy, overflow;

    int passed = 0, total = 0;
    int score_m = 0, disp_m = 0, px_m = 225, py_m = 441, en_m = 1, bl_m = 0, ov_m = 0;

    logic [7:0] fnt [80] = '{
        8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00,
        8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00,
        8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E, 8'h00,
        8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00,
        8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'h7E, 8'h0C, 8'h0C, 8'h00,
        8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00,
        8'h3C, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00,
        8'h7E, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30, 8'h00,
        8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h00,
        8'h3C, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h0C, 8'h38, 8'h00
    };

    score_overlay dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .write      (write),
        .address    (address),
        .writedata  (writedata),
        .score_inc  (score_inc),
        .hcount     (hcount),
        .vcount     (vcount),
        .pixel_on   (pixel_on),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic exp_pix(input int h, input int v);
        int x, dx, dy, i, c, d, p;
        logic [7:0] b;
        if (en_m == 0 || h >= 1280 || v >= 480) return 1'b0;
        x = h / 2;
        dx = x - px_m;
        dy = v - py_m;
        if (dx < 0 || dy < 0 || dy >= 8) return 1'b0;
        i = dx / 10;
        c = dx % 10;
        if (i >= 4 || c >= 8) return 1'b0;
        p = 10 ** (3 - i);
        d = (disp_m / p) % 10;
        if (bl_m != 0 && i < 3 && disp_m < p) return 1'b0;
        b = fnt[d * 8 + dy];
        return b[7 - c];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic wr(input int a, input int d, input bit inc);
        chipselect = 1'b1; write = 1'b1; address = 3'(a); writedata = 32'(d); score_inc = inc;
        @(posedge clk); #1;
        chipselect = 1'b0; write = 1'b0; score_inc = 1'b0;
        case (a)
            0: score_m = d > 9999 ? 9999 : d;
            1: px_m = d & 1023;
            2: py_m = d & 511;
            3: begin en_m = d & 1; bl_m = (d >> 1) & 1; if ((d & 4) != 0) ov_m = 0; end
            default: ;
        endcase
        if (inc && a != 0) begin
            if (score_m == 9999) ov_m = 1; else score_m++;
        end
    endtask

    task automatic inc1();
        score_inc = 1'b1;
        @(posedge clk); #1;
        score_inc = 1'b0;
        if (score_m == 9999) ov_m = 1; else score_m++;
    endtask

    task automatic convert(input bit inc_mid);
        int w = 0, n = 0, snap = score_m;
        vcount = 10'd480;
        while (!busy && w < 20) begin @(posedge clk); #1; w++; end
        chk("busy_start", 32'(busy), 1);
        while (busy && n < 100) begin
            score_inc = inc_mid && n == 3;
            @(posedge clk); #1;
            n++;
        end
        score_inc = 1'b0;
        vcount = 10'd100;
        if (inc_mid) score_m++;
        chk("busy_len", n, 15);
        disp_m = snap;
    endtask

    task automatic scan(input int v, input string tag);
        int h0 = px_m * 2 - 6, h1 = px_m * 2 + 86;
        if (h0 < 0) h0 = 0;
        vcount = 10'(v);
        for (int j = 0; j <= h1 - h0 + 2; j++) begin
            if (j >= 2) chk(tag, 32'(pixel_on), 32'(exp_pix(h0 + j - 2, v)));
            hcount = 11'(h0 + j);
            @(posedge clk); #1;
        end
        vcount = 10'd100;
    endtask

    task automatic probe(input int h, input int v, input int exp, input string tag);
        hcount = 11'(h); vcount = 10'(v);
        repeat (2) @(posedge clk);
        #1;
        chk(tag, 32'(pixel_on), exp);
        vcount = 10'd100;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_pixel", 32'(pixel_on), 0);
        reset = 1'b0;
        scan(441, "rst_scan_r0");
        scan(444, "rst_scan_r3");

        // digits must not change until the conversion window
        wr(3, 1, 0);
        wr(0, 1234, 0);
        repeat (20) @(posedge clk);
        #1;
        chk("busy_outside_window", 32'(busy), 0);
        scan(442, "pre_convert_scan");
        convert(0);
        scan(442, "scan_1234_r1");
        scan(446, "scan_1234_r5");

        wr(1, 100, 0);
        wr(2, 200, 0);
        wr(0, 5, 0);
        convert(0);
        scan(200, "scan_5_r0");
        probe(262, 200, 1, "five_first");
        probe(273, 200, 1, "five_last");
        probe(261, 200, 0, "five_before");
        probe(274, 200, 0, "five_after");
        probe(204, 200, 1, "zero_d0_col2");
        probe(202, 200, 0, "zero_d0_col1");
        probe(216, 200, 0, "gap_col");

        wr(3, 3, 0);
        wr(0, 7, 0);
        convert(0);
        scan(200, "blank7_r0");
        scan(204, "blank7_r4");
        probe(204, 200, 0, "blank7_d0_off");
        probe(262, 200, 1, "blank7_d3_on");
        wr(0, 0, 0);
        convert(0);
        scan(200, "blank0_r0");
        probe(264, 200, 1, "blank0_d3_on");
        probe(204, 200, 0, "blank0_d0_off");

        wr(3, 1, 0);
        wr(0, 42, 1);
        convert(0);
        scan(203, "write_beats_inc");
        inc1();
        convert(0);
        scan(203, "inc_43");

        chipselect = 1'b1; write = 1'b0; address = 3'd0; writedata = 32'd55;
        vcount = 10'd480;
        repeat (20) @(posedge clk);
        #1;
        chipselect = 1'b0;
        chk("no_write_no_convert", 32'(busy), 0);
        vcount = 10'd100;

        wr(0, 20000, 0);
        convert(0);
        scan(201, "clamp_9999");
        chk("ovf_before", 32'(overflow), 0);
        inc1();
        chk("ovf_set", 32'(overflow), ov_m);
        scan(202, "hold_9999");
        wr(3, 5, 0);
        chk("ovf_clear", 32'(overflow), ov_m);
        scan(202, "enable_kept");

        wr(3, 0, 0);
        scan(203, "disabled");
        wr(3, 1, 0);
        wr(5, 0, 0);
        scan(203, "bad_addr_ignored");

        wr(1, 620, 0);
        scan(202, "right_edge");
        wr(1, 100, 0);

        wr(0, 100, 0);
        convert(1);
        scan(201, "mid_shift_old");
        convert(0);
        scan(201, "mid_shift_new");

        for (int k = 0; k < 6; k++) begin
            int v, n;
            do v = int'($urandom_range(0, 11000)); while ((v > 9999 ? 9999 : v) == score_m);
            wr(1, int'($urandom_range(0, 400)), 0);
            wr(2, int'($urandom_range(0, 472)), 0);
            wr(3, 1 + 2 * int'($urandom_range(0, 1)), 0);
            wr(0, v, 0);
            n = int'($urandom_range(0, 2));
            repeat (n) inc1();
            convert(0);
            chk("rand_ovf", 32'(overflow), ov_m);
            scan(py_m + int'($urandom_range(0, 7)), "rand_scan");
        end

        wr(0, 777, 0);
        vcount = 10'd480;
        for (int w = 0; w < 20 && !busy; w++) begin @(posedge clk); #1; end
        repeat (4) @(posedge clk);
        #1;
        chk("mid_shift_busy", 32'(busy), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_pixel", 32'(pixel_on), 0);
        chk("abort_overflow", 32'(overflow), 0);
        reset = 1'b0;
        vcount = 10'd100;
        score_m = 0; disp_m = 0; px_m = 225; py_m = 441; en_m = 1; bl_m = 0; ov_m = 0;
        scan(441, "post_abort_r0");
        scan(445, "post_abort_r4");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/score_overlay.md
SCORE_OVERLAY -- requirements
Module: score_overlay

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
REQ-002   NUM_DIGITS  4  decimal digits displayed, legal range 1..6.
REQ-003   SCORE_W  14  binary score width; SHALL be at least ceil(log2(10^NUM_DIGITS)).
REQ-004   SCALE_LOG2  0  glyph magnification 1<<SCALE_LOG2, legal range 0..2.
REQ-005   RESET_X / RESET_Y  225 / 441  reset position of the leftmost digit, in 640x480 pixel space.
REQ-006 Ports SHALL be, one per line: name  direction  width  meaning.
REQ-007   clk  in  1  single clock for all logic; one clock only, reset is synchronous and active-high.
REQ-008   reset  in  1  synchronous, active-high.
REQ-009   chipselect, write  in  1 each  register write strobe; a write occurs when both are 1.
REQ-010   address  in  3  register select; 0 score, 1 pos_x[9:0], 2 pos_y[8:0], 3 ctrl; other addresses are ignored.
REQ-011   writedata  in  32  write data; only the low field of each register is used.
REQ-012   score_inc  in  1  one-cycle increment request.
REQ-013   hcount  in  11  pixel clock count, 0..1599; pixel x = hcount[10:1].
REQ-014   vcount  in  10  line count, 0..524.
REQ-015   pixel_on  out  1  glyph foreground at the sampled position.
REQ-016   busy  out  1  BCD conversion in progress.
REQ-017   overflow  out  1  sticky saturation flag.

Function
REQ-018 ctrl SHALL be bit0 enable, bit1 leading-zero blank, and bit2 clear overflow; bit2 is write-one-to-clear and is not stored.
REQ-019 A score write SHALL clamp the value to MAX = 10^NUM_DIGITS-1.
REQ-020 score_inc SHALL add 1 to score; at MAX, score SHALL hold MAX and overflow SHALL set to 1.
REQ-021 When a score write and score_inc occur in the same cycle, the write SHALL win and the increment SHALL be dropped.
REQ-022 Any change to score SHALL set a dirty flag.
REQ-023 The conversion FSM SHALL have states IDLE, SHIFT and LATCH.
REQ-024 IDLE->SHIFT SHALL occur when dirty=1 and 480<=vcount<=523; this transition clears dirty and snapshots score.
REQ-025 SHIFT SHALL run double-dabble for exactly SCORE_W cycles: add 3 to each BCD nibble >=5, then shift left one bit.
REQ-026 LATCH SHALL copy the BCD digits into the display digit registers in one cycle, then return to IDLE.
REQ-027 busy SHALL be 1 in SHIFT and LATCH, so busy is high for exactly SCORE_W+1 cycles per conversion.
REQ-028 Display digits SHALL change only in LATCH, so no visible frame is torn.
REQ-029 A score change during SHIFT SHALL re-set dirty and trigger a new conversion later.
REQ-030 Geometry: S=SCALE_LOG2; cell width = 8<<S; pitch = 10<<S; digit i (0 = most significant) spans x in [pos_x+i*pitch, +8<<S) and y in [pos_y, +8<<S).
REQ-031 Glyph lookup: font row = (y-pos_y)>>S; col = (x-cell_x)>>S; bit 7-col of the row byte is the pixel, MSB leftmost.
REQ-032 pixel_on SHALL be 1 only if enable=1, hcount<1280, vcount<480, the position is inside a cell, and the glyph bit is 1.
REQ-033 Gap columns between cells SHALL be off.
REQ-034 With blank=1, zero digits more significant than the first nonzero digit SHALL be off; the least significant digit SHALL always be drawn.
REQ-035 pixel_on SHALL correspond to hcount/vcount sampled exactly 2 clk earlier and SHALL depend only on registered state.
REQ-036 Stage 1 SHALL register hit, digit code, row and col; stage 2 SHALL be the registered font ROM output plus the delayed col/hit/blank.

Reset
REQ-037 Reset SHALL set: score=0, pos_x=RESET_X, pos_y=RESET_Y, enable=1, blank=0, display digits=0, dirty=0, FSM=IDLE, overflow=0, busy=0, pixel_on=0, pipeline registers=0.
REQ-038 Reset asserted mid-conversion SHALL abort it, with busy=0 on the next cycle.

Structure
REQ-039 Package score_overlay_pkg SHALL hold the 10x8 font constant, the register address localparams and the FSM state enum.
REQ-040 The font SHALL be implemented in sub-module digit_font_rom: inputs digit 4b and row 3b, output byte 8b, one-cycle registered; codes >9 return 0.

Verification
REQ-041 Enable=1, write score=1234 at vcount=100: digits stay 0000 until vcount 480, then busy is high 15 cycles and digits become 1,2,3,4.
REQ-042 Score=9999 (NUM_DIGITS=4), pulse score_inc: score stays 9999 and overflow=1; write ctrl=0x5: overflow=0 and enable stays 1.
REQ-043 pos=(100,200), S=0, score=5 converted, blank=0: on line vcount=200, pixel_on=1 exactly for hcount 262..273, 2 cycles later ('5' row0=0x7E, digit 3 cell at x=130); digits 0..2 draw '0' row0=0x3C.
REQ-044 Blank=1, score=7: only the digit-3 cell produces pixels; score=0: the digit-3 '0' is still drawn.
REQ-045 Write score=42 and score_inc in the same cycle: score=42; a later score_inc gives 43.
REQ-046 Assert reset during SHIFT: next cycle busy=0, pixel_on=0, digits 0000, pos=(225,441).
